// File: rtl/control_unit_if.sv
// control_unit_if -- bundle of the control unit's fetch/ALU/status signals.
//   run        : fetch permit (environment -> control unit)
//   imem_addr  : instruction memory address (control unit -> memory)
//   imem_data  : instruction word, valid one cycle after imem_addr
//   alu_func   : ALU function select (00 clr, 01 q+1, 10 q+p, 11 q-1)
//   alu_z      : ALU zero flag for the current function/operands
//   reg_sel    : destination / q-source register index
//   reg_we     : one-cycle register write strobe
//   pc, zflag, halted : architectural status
// The master modport is the control unit's view; slave is the environment's.
interface control_unit_if;
  logic       run;
  logic [4:0] imem_addr;
  logic [7:0] imem_data;
  logic [1:0] alu_func;
  logic       alu_z;
  logic [1:0] reg_sel;
  logic       reg_we;
  logic [4:0] pc;
  logic       zflag;
  logic       halted;

  modport master (
    input  run, imem_data, alu_z,
    output imem_addr, alu_func, reg_sel, reg_we, pc, zflag, halted
  );

  modport slave (
    output run, imem_data, alu_z,
    input  imem_addr, alu_func, reg_sel, reg_we, pc, zflag, halted
  );
endinterface

// File: rtl/control_unit.sv
// control_unit -- tiny FETCH/DECODE/EXEC sequencer for a 4-register
// accumulator datapath with JMP, BNZ, NOP and HALT.
//   clk : clock, all state changes on its rising edge
//   rst : synchronous active-high reset
//   bus : control_unit_if.master (see interface file for signal list)
// Instruction word: ir[7:5] opcode, ir[4:0] jump target, ir[1:0] register.
module control_unit #(
  parameter logic [4:0] RESET_PC = 5'd0
) (
  input  logic           clk,
  input  logic           rst,
  control_unit_if.master bus
);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2,
    HALT   = 2'd3
  } state_t;

  state_t     r_state;
  state_t     w_next_state;
  logic [4:0] r_pc;
  logic [4:0] w_next_pc;
  logic [7:0] r_ir;
  logic [7:0] w_next_ir;
  logic       r_zflag;
  logic       w_next_zflag;
  logic [1:0] w_alu_func;
  logic [1:0] w_reg_sel;
  logic       w_reg_we;
  logic [2:0] w_opcode;

  assign w_opcode = r_ir[7:5];

  // Next-state, next-architectural-state and EXEC-cycle datapath controls.
  always_comb begin
    w_next_state = r_state;
    w_next_pc    = r_pc;
    w_next_ir    = r_ir;
    w_next_zflag = r_zflag;
    w_alu_func   = 2'b00;
    w_reg_sel    = 2'b00;
    w_reg_we     = 1'b0;
    case (r_state)
      FETCH: begin
        // run is only looked at here, so a drop mid-instruction stalls next FETCH
        if (bus.run) begin
          w_next_state = DECODE;
        end else begin
          w_next_state = FETCH;
        end
      end
      DECODE: begin
        w_next_ir    = bus.imem_data;
        w_next_pc    = r_pc + 5'd1;  // 5-bit add wraps 31 -> 0
        w_next_state = EXEC;
      end
      EXEC: begin
        w_next_state = FETCH;
        case (w_opcode)
          3'b000, 3'b001, 3'b010, 3'b011: begin
            w_alu_func   = w_opcode[1:0];
            w_reg_sel    = r_ir[1:0];
            w_reg_we     = 1'b1;
            w_next_zflag = bus.alu_z;
          end
          3'b100: begin
            w_next_pc = r_ir[4:0];
          end
          3'b101: begin
            if (!r_zflag) begin
              w_next_pc = r_ir[4:0];
            end else begin
              w_next_pc = r_pc;
            end
          end
          3'b110: begin
            w_next_state = FETCH;
          end
          3'b111: begin
            w_next_state = HALT;
          end
          default: begin
            w_next_state = FETCH;
          end
        endcase
      end
      HALT: begin
        w_next_state = HALT;
      end
      default: begin
        w_next_state = FETCH;
      end
    endcase
  end

  // State and architectural registers; reset wins over every transition.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= FETCH;
      r_pc    <= RESET_PC;
      r_ir    <= 8'h00;
      r_zflag <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_pc    <= w_next_pc;
      r_ir    <= w_next_ir;
      r_zflag <= w_next_zflag;
    end
  end

  assign bus.imem_addr = r_pc;
  assign bus.pc        = r_pc;
  assign bus.zflag     = r_zflag;
  assign bus.halted    = (r_state == HALT);
  assign bus.alu_func  = w_alu_func;
  assign bus.reg_sel   = w_reg_sel;
  assign bus.reg_we    = w_reg_we;

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit -- directed, table-driven check of control_unit.
// Memory model returns mem[imem_addr] one clock after the address.
module tb_control_unit;

  logic clk;
  logic rst;
  logic [7:0] mem [32];
  int n_tests;
  int n_fail;

  control_unit_if bus ();

  control_unit #(.RESET_PC(5'd0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous instruction memory
  always @(posedge clk) begin
    bus.imem_data <= mem[bus.imem_addr];
  end

  typedef struct {
    logic       run;
    logic       alu_z;
    logic [4:0] e_pc;
    logic       e_we;
    logic [1:0] e_func;
    logic [1:0] e_sel;
    logic       e_z;
    logic       e_h;
  } vec_t;

  vec_t tbl [16];

  // Drive one cycle of inputs, check outputs mid-cycle, then cross the edge.
  task automatic step(input logic s_rst, input logic s_run, input logic s_z,
                      input logic [4:0] e_pc, input logic e_we,
                      input logic [1:0] e_func, input logic [1:0] e_sel,
                      input logic e_z, input logic e_h, input string nm);
    logic [16:0] act;
    logic [16:0] exp;
    rst       = s_rst;
    bus.run   = s_run;
    bus.alu_z = s_z;
    @(negedge clk);
    act = {bus.imem_addr, bus.pc, bus.reg_we, bus.alu_func, bus.reg_sel, bus.zflag, bus.halted};
    exp = {e_pc, e_pc, e_we, e_func, e_sel, e_z, e_h};
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got addr/pc/we/func/sel/z/h=%h/%h/%b/%b/%b/%b/%b expected %h/%h/%b/%b/%b/%b/%b",
               nm, act[16:12], act[11:7], act[6], act[5:4], act[3:2], act[1], act[0],
               exp[16:12], exp[11:7], exp[6], exp[5:4], exp[3:2], exp[1], exp[0]);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    bus.run = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic fill_nop();
    for (int i = 0; i < 32; i++) mem[i] = 8'hC0;
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    rst       = 1'b1;
    bus.run   = 1'b0;
    bus.alu_z = 1'b0;

    // DEC z=1 / BNZ not taken, DEC z=0 / BNZ taken to 31, NOP at 31 wraps pc
    //            run   alu_z pc     we    func   sel    z     h
    tbl[0]  = '{1'b1, 1'b0, 5'd0,  1'b0, 2'd0, 2'd0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 5'd0,  1'b0, 2'd0, 2'd0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 5'd1,  1'b1, 2'd3, 2'd1, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 5'd1,  1'b0, 2'd0, 2'd0, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 5'd1,  1'b0, 2'd0, 2'd0, 1'b1, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 5'd2,  1'b0, 2'd0, 2'd0, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 5'd2,  1'b0, 2'd0, 2'd0, 1'b1, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 5'd2,  1'b0, 2'd0, 2'd0, 1'b1, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 5'd3,  1'b1, 2'd3, 2'd1, 1'b1, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 5'd3,  1'b0, 2'd0, 2'd0, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 5'd3,  1'b0, 2'd0, 2'd0, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 1'b1, 5'd4,  1'b0, 2'd0, 2'd0, 1'b0, 1'b0};
    tbl[12] = '{1'b1, 1'b0, 5'd31, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0};
    tbl[13] = '{1'b1, 1'b0, 5'd31, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0};
    tbl[14] = '{1'b1, 1'b1, 5'd0,  1'b0, 2'd0, 2'd0, 1'b0, 1'b0};
    tbl[15] = '{1'b1, 1'b0, 5'd0,  1'b0, 2'd0, 2'd0, 1'b0, 1'b0};

    fill_nop();
    mem[0] = 8'h61; mem[1] = 8'hBF; mem[2] = 8'h61; mem[3] = 8'hBF; mem[31] = 8'hC0;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      step(1'b0, tbl[i].run, tbl[i].alu_z, tbl[i].e_pc, tbl[i].e_we,
           tbl[i].e_func, tbl[i].e_sel, tbl[i].e_z, tbl[i].e_h, $sformatf("tbl[%0d]", i));
    end

    // INC D1: write strobe only in cycle 3, pc=1 after DECODE
    fill_nop();
    mem[0] = 8'h21;
    do_reset();
    step(1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, "inc_c1");
    step(1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, "inc_c2");
    step(1'b0, 1'b1, 1'b0, 5'd1, 1'b1, 2'd1, 2'd1, 1'b0, 1'b0, "inc_c3");
    step(1'b0, 1'b1, 1'b0, 5'd1, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, "inc_c4");

    // JMP 5 with alu_z high during EXEC: zflag must not move
    fill_nop();
    mem[0] = 8'h85;
    do_reset();
    step(1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, "jmp_c1");
    step(1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, "jmp_c2");
    step(1'b0, 1'b1, 1'b1, 5'd1, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, "jmp_c3");
    step(1'b0, 1'b0, 1'b1, 5'd5, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, "jmp_fetch");

    // run low stalls in FETCH; run dropped in DECODE still completes INC
    fill_nop();
    mem[0] = 8'h21;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, $sformatf("stall_%0d", i));
    end
    step(1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, "run_fetch");
    step(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, "drop_decode");
    step(1'b0, 1'b0, 1'b0, 5'd1, 1'b1, 2'd1, 2'd1, 1'b0, 1'b0, "drop_exec");
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0, 5'd1, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, $sformatf("post_stall_%0d", i));
    end

    // HALT: terminal from cycle 4, released only by rst
    fill_nop();
    mem[0] = 8'hE0;
    do_reset();
    step(1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, "halt_c1");
    step(1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, "halt_c2");
    step(1'b0, 1'b1, 1'b1, 5'd1, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, "halt_c3");
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 1'b1, 5'd1, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1, $sformatf("halted_%0d", i));
    end
    step(1'b1, 1'b1, 1'b1, 5'd1, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1, "halt_rst");
    step(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, "after_rst");

    // rst in mid-EXEC: strobe still visible, zflag not latched, back to FETCH
    fill_nop();
    mem[0] = 8'h21;
    do_reset();
    step(1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, "rx_c1");
    step(1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, "rx_c2");
    step(1'b1, 1'b1, 1'b1, 5'd1, 1'b1, 2'd1, 2'd1, 1'b0, 1'b0, "rx_exec");
    step(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, "rx_after");
    step(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, "rx_fetch");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
